// File: rtl/shift_register_bank.sv
// Purpose: chain of DEPTH registers, WIDTH bits each, with a wrapping view pointer for LEDs and 7-segment digits.
// Latency: a strobe edge updates state; outputs are combinational from state and change 1 cycle after the strobe.
// Backpressure: none; every strobe acts in the cycle it is high, and a held strobe acts once per cycle.
module shift_register_bank #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int NDIG = WIDTH / 4,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              write_strobe,
   input  logic              shift_strobe,
   input  logic              clear_strobe,
   input  logic              view_strobe,
   input  logic              rotate_mode,
   input  logic [WIDTH-1:0]  data_in,
   output logic [WIDTH-1:0]  led_head,
   output logic [WIDTH-1:0]  led_view,
   output logic [PW-1:0]     view_index,
   output logic [PW:0]       fill_count,
   output logic              full,
   output logic [7*NDIG-1:0] digits
);

   // Active-low segment patterns, bit 6 = g down to bit 0 = a.
   function automatic logic [6:0] hex2digit(input logic [3:0] nib);
      case (nib)
         4'h0: hex2digit = 7'b1000000;
         4'h1: hex2digit = 7'b1111001;
         4'h2: hex2digit = 7'b0100100;
         4'h3: hex2digit = 7'b0110000;
         4'h4: hex2digit = 7'b0011001;
         4'h5: hex2digit = 7'b0010010;
         4'h6: hex2digit = 7'b0000010;
         4'h7: hex2digit = 7'b1111000;
         4'h8: hex2digit = 7'b0000000;
         4'h9: hex2digit = 7'b0010000;
         4'hA: hex2digit = 7'b0001000;
         4'hB: hex2digit = 7'b0000011;
         4'hC: hex2digit = 7'b1000110;
         4'hD: hex2digit = 7'b0100001;
         4'hE: hex2digit = 7'b0000110;
         default: hex2digit = 7'b0001110;
      endcase
   endfunction

   logic [WIDTH-1:0] stage [DEPTH];
   logic [DEPTH-1:0] valid;
   logic [PW-1:0]    view_ptr;

   // Stage chain and valid bits: reset > clear > write/shift > hold.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
         valid <= '0;
      end else if (clear_strobe) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
         valid <= '0;
      end else begin
         if (shift_strobe) begin
            for (int i = 1; i < DEPTH; i++) begin
               stage[i] <= stage[i-1];
               valid[i] <= valid[i-1];
            end
         end
         // A write always owns stage 0, replacing the rotate / zero feed of a shift.
         if (write_strobe) begin
            stage[0] <= data_in;
            valid[0] <= 1'b1;
         end else if (shift_strobe) begin
            stage[0] <= rotate_mode ? stage[DEPTH-1] : '0;
            valid[0] <= rotate_mode ? valid[DEPTH-1] : 1'b0;
         end
      end
   end

   // View pointer wraps at DEPTH-1 so non-power-of-two depths never select a missing stage.
   always_ff @(posedge clock) begin
      if (reset) begin
         view_ptr <= '0;
      end else if (view_strobe) begin
         view_ptr <= (view_ptr == PW'(DEPTH - 1)) ? '0 : view_ptr + 1'b1;
      end
   end

   // Viewed stage selected with an explicit compare so unused pointer codes read as zero.
   always_comb begin
      led_view = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (view_ptr == PW'(i)) led_view = stage[i];
      end
   end

   // Popcount of the valid bits.
   always_comb begin
      fill_count = '0;
      for (int i = 0; i < DEPTH; i++) begin
         fill_count = fill_count + (PW+1)'(valid[i]);
      end
   end

   // Slice 0 carries the most significant nibble of the viewed stage.
   always_comb begin
      digits = '0;
      for (int k = 0; k < NDIG; k++) begin
         digits[7*k +: 7] = hex2digit(led_view[4*(NDIG-1-k) +: 4]);
      end
   end

   assign led_head   = stage[0];
   assign view_index = view_ptr;
   assign full       = (fill_count == (PW+1)'(DEPTH));

endmodule

// File: tb/tb_shift_register_bank.sv
// Directed bench for shift_register_bank at WIDTH=8, DEPTH=4.
module tb_shift_register_bank;

   logic        clock;
   logic        reset;
   logic        write_strobe;
   logic        shift_strobe;
   logic        clear_strobe;
   logic        view_strobe;
   logic        rotate_mode;
   logic [7:0]  data_in;
   logic [7:0]  led_head;
   logic [7:0]  led_view;
   logic [1:0]  view_index;
   logic [2:0]  fill_count;
   logic        full;
   logic [13:0] digits;

   int checks = 0;
   int errors = 0;

   shift_register_bank #(.WIDTH(8), .DEPTH(4)) dut (
      .clock        (clock),
      .reset        (reset),
      .write_strobe (write_strobe),
      .shift_strobe (shift_strobe),
      .clear_strobe (clear_strobe),
      .view_strobe  (view_strobe),
      .rotate_mode  (rotate_mode),
      .data_in      (data_in),
      .led_head     (led_head),
      .led_view     (led_view),
      .view_index   (view_index),
      .fill_count   (fill_count),
      .full         (full),
      .digits       (digits)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One cycle of strobes (w, s, c, v) with data d, then return strobes low.
   task automatic drive(input logic w, input logic s, input logic c, input logic v, input logic [7:0] d);
      write_strobe = w;
      shift_strobe = s;
      clear_strobe = c;
      view_strobe  = v;
      data_in      = d;
      tick();
      write_strobe = 1'b0;
      shift_strobe = 1'b0;
      clear_strobe = 1'b0;
      view_strobe  = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // Read all four stages through the view port as {s0,s1,s2,s3}; four steps restore the pointer.
   task automatic read_stages(output logic [31:0] s);
      s = '0;
      for (int n = 0; n < 4; n++) begin
         s[8*(3 - int'(view_index)) +: 8] = led_view;
         drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      end
   endtask

   // Builds stages FF,01,3C,A5 from reset with zero-fill shifts.
   task automatic load_pattern();
      rotate_mode = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
   endtask

   task automatic test_reset();
      do_reset();
      repeat (3) tick();
      checks++; if (led_head !== 8'h00) begin errors++; $display("FAIL reset_head: got %h expected 00", led_head); end
      checks++; if (led_view !== 8'h00) begin errors++; $display("FAIL reset_view: got %h expected 00", led_view); end
      checks++; if (fill_count !== 3'd0) begin errors++; $display("FAIL reset_fill: got %0d expected 0", fill_count); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
      checks++; if (view_index !== 2'd0) begin errors++; $display("FAIL reset_index: got %0d expected 0", view_index); end
      checks++; if (digits !== {7'h40, 7'h40}) begin errors++; $display("FAIL reset_digits: got %h expected %h", digits, {7'h40, 7'h40}); end
   endtask

   task automatic test_overwrite();
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h12);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h34);
      checks++; if (led_head !== 8'h34) begin errors++; $display("FAIL overwrite_head: got %h expected 34", led_head); end
      checks++; if (fill_count !== 3'd1) begin errors++; $display("FAIL overwrite_fill: got %0d expected 1", fill_count); end
   endtask

   task automatic test_fill();
      logic [31:0] s;
      do_reset();
      load_pattern();
      checks++; if (led_head !== 8'hFF) begin errors++; $display("FAIL fill_head: got %h expected FF", led_head); end
      checks++; if (fill_count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d expected 4", fill_count); end
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b expected 1", full); end
      read_stages(s);
      checks++; if (s !== 32'hFF013CA5) begin errors++; $display("FAIL fill_stages: got %h expected FF013CA5", s); end
   endtask

   task automatic test_zero_shift();
      logic [31:0] s;
      rotate_mode = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      checks++; if (fill_count !== 3'd3) begin errors++; $display("FAIL zshift_fill: got %0d expected 3", fill_count); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL zshift_full: got %b expected 0", full); end
      read_stages(s);
      checks++; if (s !== 32'h00FF013C) begin errors++; $display("FAIL zshift_stages: got %h expected 00FF013C", s); end
   endtask

   task automatic test_rotate();
      logic [31:0] s;
      logic [7:0]  heads [4];
      heads[0] = 8'hA5; heads[1] = 8'h3C; heads[2] = 8'h01; heads[3] = 8'hFF;
      do_reset();
      load_pattern();
      rotate_mode = 1'b1;
      for (int n = 0; n < 4; n++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
         checks++; if (led_head !== heads[n]) begin errors++; $display("FAIL rotate_head[%0d]: got %h expected %h", n, led_head, heads[n]); end
         checks++; if (fill_count !== 3'd4) begin errors++; $display("FAIL rotate_fill[%0d]: got %0d expected 4", n, fill_count); end
      end
      read_stages(s);
      checks++; if (s !== 32'hFF013CA5) begin errors++; $display("FAIL rotate_stages: got %h expected FF013CA5", s); end
   endtask

   task automatic test_write_shift();
      logic [31:0] s;
      do_reset();
      rotate_mode = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h44);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h33);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h22);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
      rotate_mode = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
      checks++; if (fill_count !== 3'd4) begin errors++; $display("FAIL wshift_fill: got %0d expected 4", fill_count); end
      read_stages(s);
      checks++; if (s !== 32'h77112233) begin errors++; $display("FAIL wshift_stages: got %h expected 77112233", s); end
   endtask

   task automatic test_view();
      logic [1:0] seq [5];
      seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd0; seq[4] = 2'd1;
      do_reset();
      rotate_mode = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);
      for (int n = 0; n < 5; n++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
         checks++; if (view_index !== seq[n]) begin errors++; $display("FAIL view_seq[%0d]: got %0d expected %0d", n, view_index, seq[n]); end
         if (n == 1) begin
            checks++; if (led_view !== 8'h00) begin errors++; $display("FAIL view_empty: got %h expected 00", led_view); end
         end
      end
      checks++; if (led_view !== 8'h3C) begin errors++; $display("FAIL view_data: got %h expected 3C", led_view); end
      checks++; if (digits !== {7'h46, 7'h30}) begin errors++; $display("FAIL view_digits: got %h expected %h", digits, {7'h46, 7'h30}); end
   endtask

   task automatic test_clear_write();
      logic [31:0] s;
      drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h99);
      checks++; if (led_head !== 8'h00) begin errors++; $display("FAIL clear_head: got %h expected 00", led_head); end
      checks++; if (fill_count !== 3'd0) begin errors++; $display("FAIL clear_fill: got %0d expected 0", fill_count); end
      checks++; if (view_index !== 2'd1) begin errors++; $display("FAIL clear_index: got %0d expected 1", view_index); end
      read_stages(s);
      checks++; if (s !== 32'h00000000) begin errors++; $display("FAIL clear_stages: got %h expected 00000000", s); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      load_pattern();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      reset = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h55);
      reset = 1'b0;
      checks++; if (led_head !== 8'h00) begin errors++; $display("FAIL rmid_head: got %h expected 00", led_head); end
      checks++; if (fill_count !== 3'd0) begin errors++; $display("FAIL rmid_fill: got %0d expected 0", fill_count); end
      checks++; if (view_index !== 2'd0) begin errors++; $display("FAIL rmid_index: got %0d expected 0", view_index); end
      checks++; if (led_view !== 8'h00) begin errors++; $display("FAIL rmid_view: got %h expected 00", led_view); end
   endtask

   initial begin
      reset        = 1'b1;
      write_strobe = 1'b0;
      shift_strobe = 1'b0;
      clear_strobe = 1'b0;
      view_strobe  = 1'b0;
      rotate_mode  = 1'b0;
      data_in      = 8'h00;
      test_reset();
      test_overwrite();
      test_fill();
      test_zero_shift();
      test_rotate();
      test_write_shift();
      test_view();
      test_clear_write();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_register_bank.md
Name: shift_register_bank

Overview:
- Parametrised multi-stage storage register for the board designs.
- A chain of DEPTH registers, each WIDTH bits wide, loaded from the switches and shifted down the chain, with an optional rotate (circular) mode.
- A wrapping view pointer selects one stage to show on the LEDs and on the 7-segment digits.
- Sits between the button_handler_down instances (which supply one-cycle strobes) and the LED / hex2digit display outputs at the board top level.

Parameters:
- WIDTH, 8, bits per stage; must be a multiple of 4 and at least 4.
- DEPTH, 4, number of stages; must be at least 2. Non-power-of-two values are legal.
- NDIG (localparam), WIDTH/4, number of 7-segment digits.
- PW (localparam), $clog2(DEPTH), width of the view pointer.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- write_strobe  input  1  one-cycle pulse: load data_in into stage 0.
- shift_strobe  input  1  one-cycle pulse: advance the chain by one stage.
- clear_strobe  input  1  one-cycle pulse: zero all stages and all valid bits.
- view_strobe  input  1  one-cycle pulse: advance the view pointer.
- rotate_mode  input  1  level; 1 = circular shift, 0 = zero-fill shift.
- data_in  input  WIDTH  switch value.
- led_head  output  WIDTH  contents of stage 0.
- led_view  output  WIDTH  contents of the stage selected by view_index.
- view_index  output  PW  current view pointer.
- fill_count  output  PW+1  number of valid stages, 0..DEPTH.
- full  output  1  high when fill_count == DEPTH.
- digits  output  7*NDIG  segment patterns for led_view, one 7-bit slice per nibble.

Behaviour:
- State: stage[0..DEPTH-1] (WIDTH bits each), valid[0..DEPTH-1], view pointer (PW bits).
- All state registered. Every output is combinational from state, so an effect is visible on outputs 1 cycle after the strobe edge.
- Reset (synchronous, active-high, overrides everything):
  - All stages 0, all valid bits 0, view pointer 0.
  - Resulting outputs: led_head=0, led_view=0, view_index=0, fill_count=0, full=0, every digit slice = hex2digit(0).
  - Reset mid-operation discards any strobe in the same cycle.
- Priority, highest first: reset > clear > write/shift > idle.
- clear_strobe: all stages and valid bits go to 0. The view pointer is unchanged. Write and shift strobes in the same cycle are ignored.
- write_strobe alone: stage[0]<=data_in, valid[0]<=1. Other stages unchanged. Overwrites stage 0 even if it is already valid.
- shift_strobe alone: stage[i]<=stage[i-1] and valid[i]<=valid[i-1] for i=1..DEPTH-1. Stage 0 feed:
  - rotate_mode=1: stage[0]<=stage[DEPTH-1], valid[0]<=valid[DEPTH-1]; no data is lost.
  - rotate_mode=0: stage[0]<=0, valid[0]<=0; stage[DEPTH-1] falls off the end.
- write_strobe and shift_strobe together: the shift is performed, but stage 0 takes data_in and valid[0]<=1, replacing the rotate/zero feed.
- view_strobe: pointer <= (pointer==DEPTH-1) ? 0 : pointer+1. Acts independently of, and in the same cycle as, any other strobe except reset.
- led_view and digits always reflect the stage contents as registered, including while the pointer moves.
- fill_count = popcount(valid). full is derived from fill_count.
- digits mapping: slice k (bits 7k+6..7k) = hex2digit of nibble (NDIG-1-k) of led_view, so slice 0 shows the most significant nibble. Segment encoding is exactly that of hex2digit.
- Strobes are assumed to be single-cycle. A strobe held high acts once per cycle; there is no edge detection inside this block.

Test Plan (WIDTH=8, DEPTH=4):
- Reset, then idle 3 cycles -> led_head=0x00, fill_count=0, full=0, view_index=0, digits = two "0" glyphs.
- Write 0xA5, then shift, write 0x3C, shift, write 0x01, shift, write 0xFF (rotate_mode=0) -> stages = FF,01,3C,A5; fill_count=4; full=1.
- From that state, rotate_mode=0, one shift -> stages = 00,FF,01,3C; fill_count=3; full=0; 0xA5 lost.
- From stages FF,01,3C,A5 with rotate_mode=1, 4 shifts -> stages return to FF,01,3C,A5; fill_count stays 4 throughout.
- write_strobe with data_in=0x77 and shift_strobe in the same cycle, from stages 11,22,33,44, rotate_mode=1 -> stages = 77,11,22,33; 0x44 lost.
- view_strobe 5 times -> view_index sequence 1,2,3,0,1. With view_index=1 and stage[1]=0x3C, digits slice 0 = glyph "3", slice 1 = glyph "C".
- clear_strobe together with write_strobe -> all stages 0, fill_count=0, view_index unchanged.
- Assert reset during a shift -> the cycle after shows all-zero state.
